// File: rtl/mult18_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mult18_share_arb
// Purpose  : Round-robin arbiter sharing one registered 18x18 signed multiplier
//            among NREQ requesters, with in-order tagged result return.
// Revision : 1.0 - initial release
// ============================================================================
module mult18_share_arb #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [18*NREQ-1:0]   i_req_a,
    input  logic [18*NREQ-1:0]   i_req_b,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    output logic [35:0]          o_res_p,
    output logic [NREQ-1:0]      o_res_valid,
    output logic [17:0]          o_m_a,
    output logic [17:0]          o_m_b,
    output logic                 o_m_cea,
    output logic                 o_m_ceb,
    output logic                 o_m_cep,
    output logic                 o_m_rsta,
    output logic                 o_m_rstb,
    output logic                 o_m_rstp,
    input  logic [35:0]          i_m_p,
    output logic                 o_busy,
    output logic [1:0]           o_outstanding
);

    localparam int            PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]   C_NREQ  = (PW+1)'(NREQ);
    localparam logic [PW-1:0] C_LAST  = PW'(NREQ - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [PW-1:0]  r_ptr;
    logic [PW-1:0]  w_ptr_nxt;
    logic [17:0]    w_req_a [NREQ];
    logic [17:0]    w_req_b [NREQ];
    logic [PW-1:0]  w_rot_idx [NREQ];
    logic           w_gnt_found;
    logic [PW-1:0]  w_gnt_idx;
    logic           w_hs;

    logic [17:0]    r_m_a;
    logic [17:0]    r_m_b;
    logic [LAT-1:0] r_tag_vld;
    logic [PW-1:0]  r_tag_id [LAT];
    logic [35:0]    r_res_p;
    logic [1:0]     w_outstanding;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_req_a[gi] = i_req_a[18*gi +: 18];
            assign w_req_b[gi] = i_req_b[18*gi +: 18];
        end

        // Candidate order for this cycle: pointer, pointer+1, ... with wrap
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [PW:0] w_rot_sum;
            assign w_rot_sum     = {1'b0, r_ptr} + (PW+1)'(gi);
            assign w_rot_idx[gi] = (w_rot_sum >= C_NREQ) ? PW'(w_rot_sum - C_NREQ)
                                                         : PW'(w_rot_sum);
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_gnt_found && i_req_valid[w_rot_idx[k]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_rot_idx[k];
            end
        end
    end

    assign w_hs      = (r_state == ST_RUN) && w_gnt_found;
    assign w_ptr_nxt = (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + 1'b1;

    assign o_req_ready = w_hs ? (NREQ'(1) << w_gnt_idx) : '0;

    // Operands reach the multiplier in the handshake cycle; otherwise the last
    // issued pair is held so the A/B pins stay quiet.
    assign o_m_a    = w_hs ? w_req_a[w_gnt_idx] : r_m_a;
    assign o_m_b    = w_hs ? w_req_b[w_gnt_idx] : r_m_b;
    assign o_m_cea  = w_hs;
    assign o_m_ceb  = w_hs;
    assign o_m_rsta = (r_state == ST_INIT);
    assign o_m_rstb = (r_state == ST_INIT);
    assign o_m_rstp = (r_state == ST_INIT);

    generate
        if (LAT >= 2) begin : g_cep_pipe
            assign o_m_cep = r_tag_vld[LAT-2];
        end else begin : g_cep_direct
            assign o_m_cep = w_hs;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_INIT;
            r_ptr     <= '0;
            r_m_a     <= '0;
            r_m_b     <= '0;
            r_tag_vld <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_tag_id[k] <= '0;
            end
            r_res_p   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_ptr <= w_ptr_nxt;
                r_m_a <= w_req_a[w_gnt_idx];
                r_m_b <= w_req_b[w_gnt_idx];
            end
            r_tag_vld[0] <= w_hs;
            r_tag_id[0]  <= w_gnt_idx;
            for (int k = 1; k < LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
            if (r_tag_vld[LAT-1]) begin
                r_res_p <= i_m_p;
            end
        end
    end

    // The last tag stage lines up with the P register being valid.
    assign o_res_p     = r_tag_vld[LAT-1] ? i_m_p : r_res_p;
    assign o_res_valid = r_tag_vld[LAT-1] ? (NREQ'(1) << r_tag_id[LAT-1]) : '0;

    always_comb begin
        w_outstanding = '0;
        for (int k = 0; k < LAT; k++) begin
            w_outstanding = w_outstanding + {1'b0, r_tag_vld[k]};
        end
    end

    assign o_outstanding = w_outstanding;
    assign o_busy        = |r_tag_vld;

endmodule
`default_nettype wire

// File: tb/tb_mult18_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult18_share_arb
// Purpose  : Self-checking bench: multiplier primitive model, per-cycle
//            reference model compare, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult18_share_arb;

    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [18*NREQ-1:0]   req_a;
    logic [18*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [35:0]          res_p;
    logic [NREQ-1:0]      res_valid;
    logic [17:0]          m_a, m_b;
    logic                 m_cea, m_ceb, m_cep;
    logic                 m_rsta, m_rstb, m_rstp;
    logic [35:0]          m_p;
    logic                 busy;
    logic [1:0]           outstanding;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult18_share_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_a       (req_a),
        .i_req_b       (req_b),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .o_res_p       (res_p),
        .o_res_valid   (res_valid),
        .o_m_a         (m_a),
        .o_m_b         (m_b),
        .o_m_cea       (m_cea),
        .o_m_ceb       (m_ceb),
        .o_m_cep       (m_cep),
        .o_m_rsta      (m_rsta),
        .o_m_rstb      (m_rstb),
        .o_m_rstp      (m_rstp),
        .i_m_p         (m_p),
        .o_busy        (busy),
        .o_outstanding (outstanding)
    );

    // Registered 18x18 signed multiplier primitive (AREG=BREG=PREG=1)
    logic signed [17:0] mr_a, mr_b;
    logic signed [35:0] mr_p;
    always @(posedge clk) begin
        if (m_rsta) mr_a <= '0; else if (m_cea) mr_a <= m_a;
        if (m_rstb) mr_b <= '0; else if (m_ceb) mr_b <= m_b;
        if (m_rstp) mr_p <= '0; else if (m_cep) mr_p <= mr_a * mr_b;
    end
    assign m_p = mr_p;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int r, input logic [17:0] a, input logic [17:0] b);
        req_a[18*r +: 18] = a;
        req_b[18*r +: 18] = b;
    endtask

    // Reference model: issue list of {due cycle, requester, product}
    typedef struct {
        int          due;
        int          id;
        logic [35:0] p;
    } ent_t;

    ent_t        q[$];
    int          m_ptr    = 0;
    bit          m_init   = 1'b1;
    logic [35:0] m_last_p = '0;
    logic [17:0] m_last_a = '0;
    logic [17:0] m_last_b = '0;
    int          cyc      = 0;

    always @(negedge clk) begin : compare
        logic [NREQ-1:0]    e_rdy;
        logic [NREQ-1:0]    e_rv;
        logic signed [17:0] ea, eb;
        logic signed [35:0] pp;
        ent_t               ne;
        int                 g;
        int                 idx;
        bit                 e_cep;
        if (!rst_n) begin
            q.delete();
            m_ptr    = 0;
            m_init   = 1'b1;
            m_last_p = '0;
            m_last_a = '0;
            m_last_b = '0;
            chk("rst_ready", req_ready, '0);
            chk("rst_res_valid", res_valid, '0);
            chk("rst_res_p", res_p, '0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_outstanding", outstanding, 2'd0);
            chk("rst_m_rst", {m_rsta, m_rstb, m_rstp}, 3'b111);
            chk("rst_m_ce", {m_cea, m_ceb, m_cep}, 3'b000);
            chk("rst_m_ab", {m_a, m_b}, 36'd0);
        end else begin
            cyc++;
            e_rdy = '0;
            g     = -1;
            if (!m_init) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) e_rdy[g] = 1'b1;
            chk("ready", req_ready, e_rdy);
            chk("m_rst", {m_rsta, m_rstb, m_rstp}, m_init ? 3'b111 : 3'b000);
            chk("outstanding", outstanding, q.size());
            chk("busy", busy, q.size() != 0);
            e_cep = 1'b0;
            foreach (q[i]) if (q[i].due == cyc + LAT - 1) e_cep = 1'b1;
            chk("m_cep", m_cep, e_cep);
            e_rv = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e_rv[q[0].id] = 1'b1;
                m_last_p      = q[0].p;
                void'(q.pop_front());
            end
            chk("res_valid", res_valid, e_rv);
            chk("res_p", res_p, m_last_p);
            chk("m_ce_ab", {m_cea, m_ceb}, (g >= 0) ? 2'b11 : 2'b00);
            if (g >= 0) begin
                ea       = req_a[18*g +: 18];
                eb       = req_b[18*g +: 18];
                pp       = ea * eb;
                ne.due   = cyc + LAT;
                ne.id    = g;
                ne.p     = pp;
                q.push_back(ne);
                m_ptr    = (g + 1) % NREQ;
                m_last_a = ea;
                m_last_b = eb;
            end
            chk("m_a", m_a, m_last_a);
            chk("m_b", m_b, m_last_b);
            m_init = 1'b0;
        end
    end

    logic [NREQ-1:0] mix_pat [7];

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        set_op(0, 18'd7,     18'h3FFFF);
        set_op(1, 18'd100,   18'd200);
        set_op(2, 18'h3FB2E, 18'd321);
        set_op(3, 18'h1FFFF, 18'd2);
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // INIT cycle, then round-robin over all four requesters
        @(negedge clk);
        chk("init_ready", req_ready, 4'b0000);
        chk("init_m_rst", {m_rsta, m_rstb, m_rstp}, 3'b111);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, 4'b0001 << (k % 4));
            if (k >= 2) chk("rr_outstanding", outstanding, 2'd2);
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(posedge clk);
        #1;

        // Single op from requester 2: -3 * 5
        set_op(2, 18'h3FFFD, 18'd5);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_grant", req_ready, 4'b0100);
        chk("single_cea_t", m_cea, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("single_cea_t1", m_cea, 1'b0);
        chk("single_cep_t1", m_cep, 1'b1);
        chk("single_rv_t1", res_valid, 4'b0000);
        @(negedge clk);
        chk("single_rv_t2", res_valid, 4'b0100);
        chk("single_p_t2", res_p, 36'hFFFFFFFF1);
        chk("single_cep_t2", m_cep, 1'b0);

        // Pointer now at 3: wrap to 0, skip to 2, back to 0
        @(posedge clk); #1 req_valid = 4'b0101;
        @(negedge clk); chk("wrap_g0", req_ready, 4'b0001);
        @(posedge clk); #1;
        @(negedge clk); chk("wrap_g2", req_ready, 4'b0100);
        @(posedge clk); #1;
        @(negedge clk); chk("wrap_g0b", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        repeat (2) @(posedge clk);
        #1;

        // Corner products back to back from requester 1
        set_op(1, 18'h1FFFF, 18'h1FFFF);
        req_valid = 4'b0010;
        @(posedge clk); #1 set_op(1, 18'h20000, 18'h20000);
        @(posedge clk); #1 set_op(1, 18'h20000, 18'h1FFFF);
        @(negedge clk);
        chk("corner_max_rv", res_valid, 4'b0010);
        chk("corner_max", res_p, 36'h3FFFC0001);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk); chk("corner_min", res_p, 36'h400000000);
        @(negedge clk); chk("corner_mixed", res_p, 36'hC00020000);
        repeat (2) @(posedge clk);
        #1;

        // Mid-flight reset: ops issued, reset lands before any result
        req_valid = 4'b1111;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("mid_init_rst", {m_rsta, m_rstb, m_rstp}, 3'b111);
        chk("mid_busy", busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mid_no_result", res_valid, 4'b0000);
        end

        // Mixed request patterns, checked by the reference model
        mix_pat[0] = 4'b1010; mix_pat[1] = 4'b0110; mix_pat[2] = 4'b1111;
        mix_pat[3] = 4'b0001; mix_pat[4] = 4'b1000; mix_pat[5] = 4'b0000;
        mix_pat[6] = 4'b1100;
        set_op(0, 18'h20000, 18'd3);
        set_op(1, 18'h0ABCD, 18'h3F00F);
        set_op(2, 18'd0,     18'h1FFFF);
        set_op(3, 18'h3FFFF, 18'h3FFFF);
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1 req_valid = mix_pat[k];
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("end_idle_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
